// File: rtl/illum_uart_reporter_pkg.sv
// Shared constants and types for the illumination UART reporter.
package illum_uart_reporter_pkg;

    // Number of bytes in one report line: flag, two hex digits, CR, LF.
    localparam int FRAME_BYTES = 5;

    localparam logic [7:0] FLAG_SET       = 8'h21;
    localparam logic [7:0] FLAG_CLR       = 8'h2E;
    localparam logic [7:0] CR             = 8'h0D;
    localparam logic [7:0] LF             = 8'h0A;
    localparam logic [7:0] HEX_DIGIT_BASE = 8'h30;
    localparam logic [7:0] HEX_ALPHA_BASE = 8'h41;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Uppercase ASCII hex character for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return HEX_DIGIT_BASE + {4'h0, nibble};
        end
        return HEX_ALPHA_BASE + {4'h0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/illum_uart_reporter_tx_byte.sv
// 8N1 bit-timing engine: sends one byte per start request, LSB first.
// The data input is read live while bits are shifted out, so the caller
// must hold it stable for the whole byte. Asserting start in the final
// stop-bit cycle (when ready is high) chains the next byte with no idle gap.
module uart_tx_byte
    import illum_uart_reporter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TX,
    output logic       ready
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t      state, state_next;
    logic [CW-1:0]  clk_cnt, clk_cnt_next;
    logic [2:0]     bit_idx, bit_idx_next;
    logic           tx_next;
    logic           bit_end;

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

    // State, bit timer, bit index and the registered TX line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            TX      <= 1'b1;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            TX      <= tx_next;
        end
    end

    // Next-state logic; TX for the coming cycle is decided at each bit boundary.
    always_comb begin
        state_next   = state;
        clk_cnt_next = bit_end ? '0 : clk_cnt + CW'(1);
        bit_idx_next = bit_idx;
        tx_next      = TX;
        case (state)
            IDLE: begin
                clk_cnt_next = '0;
                tx_next      = 1'b1;
                if (start) begin
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                    tx_next      = data[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = data[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (start) begin
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/illum_uart_reporter.sv
// Periodic illumination/alarm reporter: snapshots the light level and a
// sticky motion flag on each report tick and sends "<flag><HH>\r\n" over UART.
module illum_uart_reporter
    import illum_uart_reporter_pkg::*;
#(
    parameter int CLK_HZ        = 100000000,
    parameter int BAUD          = 115200,
    parameter int REPORT_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] illum,
    input  logic       alarm,
    output logic       TX,
    output logic       busy,
    output logic       overrun
);

    localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int         CNT_W        = $clog2(REPORT_CYCLES);
    localparam logic [2:0] LAST_BYTE    = 3'(FRAME_BYTES - 1);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             capture;
    logic             sticky;
    logic [7:0]       cap_illum;
    logic             cap_flag;
    logic [2:0]       byte_idx;
    logic             tx_start;
    logic             tx_ready;
    logic [7:0]       tx_data;

    assign tick     = enable && (tick_cnt == CNT_W'(REPORT_CYCLES - 1));
    assign capture  = tick && !busy;
    assign overrun  = tick && busy;
    assign tx_start = capture || (busy && tx_ready && (byte_idx != LAST_BYTE));

    // Report period counter; disabling reporting parks it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Sticky alarm: cleared only by an accepted capture, never by a dropped tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else if (capture) begin
            sticky <= 1'b0;
        end else if (alarm) begin
            sticky <= 1'b1;
        end
    end

    // Snapshot of the values that the frame in flight reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_illum <= 8'h00;
            cap_flag  <= 1'b0;
        end else if (capture) begin
            cap_illum <= illum;
            cap_flag  <= sticky | alarm;
        end
    end

    // Frame sequencing: byte index advances at the end of each stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            byte_idx <= 3'd0;
        end else if (capture) begin
            busy     <= 1'b1;
            byte_idx <= 3'd0;
        end else if (busy && tx_ready) begin
            if (byte_idx == LAST_BYTE) begin
                busy <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 3'd1;
            end
        end
    end

    // Byte selection for the current position in the line.
    always_comb begin
        tx_data = LF;
        case (byte_idx)
            3'd0:    tx_data = cap_flag ? FLAG_SET : FLAG_CLR;
            3'd1:    tx_data = hex_ascii(cap_illum[7:4]);
            3'd2:    tx_data = hex_ascii(cap_illum[3:0]);
            3'd3:    tx_data = CR;
            default: tx_data = LF;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .data  (tx_data),
        .TX    (TX),
        .ready (tx_ready)
    );

endmodule

// File: doc/illum_uart_reporter.md
Name: illum_uart_reporter

Overview:
- Downstream consumer of the ambient-light reading (8-bit `illum`) and the accelerometer interrupt.
- Periodically snapshots the current illumination and a sticky alarm flag.
- Formats them as a 5-byte ASCII line and serializes it 8N1 on the board TX pin.
- Gives the host a human-readable log of light level and motion events.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 2)
REPORT_CYCLES, 10000000, clock cycles between report ticks (must be > 50*CLKS_PER_BIT)

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-low reset
enable  input  1  high: report ticks generated; low: tick counter held at 0
illum  input  8  current illumination value, sampled only at capture
alarm  input  1  active-high motion alarm (inverted INT_ACL2), level, any width
TX  output  1  UART serial out, idle high
busy  output  1  high while a frame is in flight
overrun  output  1  one-cycle pulse when a tick occurs while busy

Behaviour:
- Reset (Reset=0, asynchronous) forces:
  - TX=1, busy=0, overrun=0.
  - Tick counter=0, sticky flag=0, FSM=IDLE.
  - Reset mid-frame aborts immediately; TX returns high with no partial stop bit.
- Tick counter:
  - Counts 0..REPORT_CYCLES-1 while enable=1, then wraps.
  - Tick asserted for the one cycle in which the count equals REPORT_CYCLES-1.
  - enable=0 clears the counter synchronously; a frame already in flight still completes.
- Sticky alarm:
  - Set on any cycle with alarm=1.
  - In the capture cycle the frame flag takes sticky|alarm and sticky clears to 0.
  - An alarm that arrives in the same cycle as capture is therefore reported in the current frame, not the next.
- Capture:
  - Happens on a tick with busy=0: latch illum and the flag; busy=1 from the next cycle.
  - A tick with busy=1 is dropped: overrun=1 for that cycle, and the sticky flag is not cleared.
- Frame byte order:
  - B0 = flag: 0x21 '!' if set, else 0x2E '.'.
  - B1 = hex of illum[7:4].
  - B2 = hex of illum[3:0].
  - B3 = 0x0D.
  - B4 = 0x0A.
  - Hex encoding: nibble 0-9 gives 0x30+n; nibble 10-15 gives 0x41+(n-10) (uppercase).
- Serializer FSM: IDLE -> START -> DATA -> STOP -> (START if byte index<4, else IDLE).
  - START: TX=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; bit counter 0..7.
  - STOP: TX=1 for CLKS_PER_BIT cycles; byte index increments at the end of STOP.
  - Bytes are back-to-back, with no extra idle between a stop bit and the next start bit.
- Timing:
  - Latency: tick at cycle N means capture at N, and the start bit of B0 drives TX=0 from cycle N+1.
  - Frame length is exactly 50*CLKS_PER_BIT cycles.
  - busy falls in the cycle after the final B4 stop-bit cycle.
  - A tick in that same cycle (busy already 0) is accepted.
- TX is registered, with no combinational path from inputs.

Decomposition:
- Shared package holds:
  - ASCII constants (FLAG_SET, FLAG_CLR, CR, LF, HEX_DIGIT_BASE, HEX_ALPHA_BASE).
  - The serializer state enum (IDLE, START, DATA, STOP).
  - The frame length constant FRAME_BYTES=5.
- One sub-module, uart_tx_byte:
  - Handles 8N1 bit timing only.
  - Inputs: start, data[7:0]. Outputs: TX, ready.
- The top block owns the tick counter, sticky flag, capture registers, byte index and hex mux.

Test Plan:
- Bench parameters: CLK_HZ=16, BAUD=1 (CLKS_PER_BIT=16), REPORT_CYCLES=1000.
- Reset then enable=1, illum=0x3C, alarm=0 -> first tick at cycle 999; TX decodes ".3C\r\n" (0x2E,0x33,0x43,0x0D,0x0A); busy high for exactly 800 cycles.
- alarm pulsed 1 cycle at cycle 400, illum=0xF0 -> next frame "!F0\r\n"; the following frame (no alarm) starts with '.'.
- alarm=1 only in the capture cycle -> that frame's B0='!'; next frame's B0='.'.
- REPORT_CYCLES overridden to 500 (< frame length) -> overrun pulses at the tick during the frame; frame unchanged; sticky alarm set before that tick survives to the next accepted frame.
- Reset asserted mid-DATA of B2 -> TX=1 and busy=0 asynchronously; after release, no output until the next full tick period.
- enable dropped mid-frame -> current frame completes intact; no new start bit while enable=0; after re-enable, first tick exactly 1000 cycles later.
